left_shift_pipelined: RTL and testbench

LEFT_SHIFT_PIPELINED -- requirements
Module: left_shift_pipelined

---
 rtl/left_shift_pipelined.sv | 87 ++++++++
 tb/tb_left_shift_pipelined.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_pipelined.sv
// Pipelined logical left shifter: one radix-4 digit of the shift amount per
// registered stage, most significant digit first, with valid/ready flow control.
module left_shift_pipelined #(
  parameter int WIDTH  = 13,
  parameter int SW     = $clog2(WIDTH),
  parameter int STAGES = (SW + 1) / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    shift,
  input  logic             validIn,
  output logic             readyIn,
  output logic [WIDTH-1:0] out,
  output logic             validOut,
  input  logic             readyOut
);

  localparam int PW = 2 * STAGES;

  // 4:1 mux per bit: source bit b - d*4^s, zero where that index falls below 0
  function automatic logic [WIDTH-1:0] digit_shift(input logic [WIDTH-1:0] src,
                                                   input logic [1:0] d,
                                                   input int unsigned s);
    logic [WIDTH-1:0] r;
    r = src;
    unique case (d)
      2'd0: r = src;
      2'd1: r = src << (32'd1 << (2 * s));
      2'd2: r = src << (32'd2 << (2 * s));
      2'd3: r = src << (32'd3 << (2 * s));
      default: r = src;
    endcase
    return r;
  endfunction

  logic             advance;
  logic [PW-1:0]    shift_pad;
  logic [WIDTH-1:0] data_q [STAGES];
  logic             vld_q  [STAGES];

  // An odd SW leaves the top digit one bit short; its missing bit reads as 0
  assign shift_pad = PW'(shift);
  assign advance   = !vld_q[STAGES-1] || readyOut;
  assign readyIn   = advance;
  assign out       = data_q[STAGES-1];
  assign validOut  = vld_q[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) vld_q[i] <= 1'b0;
    end else if (advance) begin
      vld_q[0] <= validIn;
      for (int unsigned i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) data_q[0] <= digit_shift(in, shift_pad[2*(STAGES-1) +: 2], STAGES - 1);
  end

  generate
    if (STAGES > 1) begin : g_pipe
      // Shift amount travels with its data word so each stage sees its own digit
      logic [PW-1:0] sh_q [STAGES-1];

      always_ff @(posedge clk) begin
        if (advance) sh_q[0] <= shift_pad;
      end

      for (genvar k = 1; k < STAGES; k++) begin : g_stage
        localparam int unsigned S = STAGES - 1 - k;

        always_ff @(posedge clk) begin
          if (advance) data_q[k] <= digit_shift(data_q[k-1], sh_q[k-1][2*S +: 2], S);
        end

        if (k < STAGES - 1) begin : g_sh
          always_ff @(posedge clk) begin
            if (advance) sh_q[k] <= sh_q[k-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_left_shift_pipelined.sv
// Self-checking bench for left_shift_pipelined: directed table, streaming,
// back-pressure, reset flush, and randomized sweeps over several widths.
module tb_left_shift_pipelined;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sweep_done = 0;
  logic sweep_go = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Directed DUT, default WIDTH=13
  logic [12:0] in_d, out_d;
  logic [3:0]  sh_d;
  logic        vi, ri, vo, ro;

  left_shift_pipelined #(.WIDTH(13)) dut (
    .clk(clk), .reset(reset), .in(in_d), .shift(sh_d), .validIn(vi),
    .readyIn(ri), .out(out_d), .validOut(vo), .readyOut(ro)
  );

  typedef struct {
    logic [12:0] din;
    logic [3:0]  sh;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[11];
  logic [12:0] q[$];

  initial begin
    int lat;
    int oc;
    int got;
    logic [7:0] pattern;
    logic held;
    logic [12:0] held_val;
    logic any;
    int next;

    vi = 1'b0; ro = 1'b1; in_d = '0; sh_d = '0;

    vecs[0]  = '{13'h0001, 4'd5,  13'h0020};
    vecs[1]  = '{13'h1FFF, 4'd12, 13'h1000};
    vecs[2]  = '{13'h1555, 4'd1,  13'h0AAA};
    vecs[3]  = '{13'h0F0F, 4'd8,  13'h0F00};
    vecs[4]  = '{13'h1FFF, 4'd0,  13'h1FFF};
    vecs[5]  = '{13'h1234, 4'd3,  13'h11A0};
    vecs[6]  = '{13'h0ABC, 4'd4,  13'h0BC0};
    vecs[7]  = '{13'h0003, 4'd9,  13'h0600};
    vecs[8]  = '{13'h1FFF, 4'd13, 13'h0000};
    vecs[9]  = '{13'h1FFF, 4'd14, 13'h0000};
    vecs[10] = '{13'h1FFF, 4'd15, 13'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_validOut", 64'(vo), 64'd0);
    chk("reset_readyIn", 64'(ri), 64'd1);

    // Single words, one at a time, latency and value
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_d = vecs[i].din; sh_d = vecs[i].sh; vi = 1'b1; ro = 1'b1;
      #1;
      chk($sformatf("vec%0d_readyIn", i), 64'(ri), 64'd1);
      @(posedge clk); #1;
      vi = 1'b0;
      lat = 1;
      while (!vo && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_out", i), 64'(out_d), 64'(vecs[i].exp));
    end

    // Four back-to-back words with downstream always ready
    repeat (3) @(negedge clk);
    oc = 0;
    pattern = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vi = (i < 4); in_d = vecs[i % 4].din; sh_d = vecs[i % 4].sh; ro = 1'b1;
      @(posedge clk); #1;
      pattern[i] = vo;
      if (vo && oc < 4) begin
        chk($sformatf("stream_out%0d", oc), 64'(out_d), 64'(vecs[oc].exp));
        oc++;
      end
    end
    chk("stream_valid_pattern", 64'(pattern), 64'h1E);

    // Back-pressure: readyOut low for three cycles while a result is waiting
    @(negedge clk);
    vi = 1'b0;
    repeat (3) @(negedge clk);
    q.delete();
    next = 0; got = 0; held = 1'b0; held_val = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ro = !(i >= 3 && i <= 5);
      vi = (next < 4);
      in_d = vecs[4 + (next % 4)].din;
      sh_d = vecs[4 + (next % 4)].sh;
      #1;
      if (held) begin
        chk("stall_out_held", 64'(out_d), 64'(held_val));
        chk("stall_valid_held", 64'(vo), 64'd1);
      end
      if (vo && !ro) begin
        chk("stall_readyIn", 64'(ri), 64'd0);
        held = 1'b1;
        held_val = out_d;
      end else begin
        held = 1'b0;
      end
      if (vo && ro) begin
        if (q.size() > 0) chk($sformatf("stall_out%0d", got), 64'(out_d), 64'(q.pop_front()));
        else chk("stall_unexpected_out", 64'(out_d), 64'h1_0000);
        got++;
      end
      if (vi && ri) begin
        q.push_back(vecs[4 + next].exp);
        next++;
      end
    end
    chk("stall_count", 64'(got), 64'd4);
    chk("stall_queue_empty", 64'(q.size()), 64'd0);

    // Reset with two words in flight
    @(negedge clk);
    vi = 1'b1; ro = 1'b1; in_d = vecs[0].din; sh_d = vecs[0].sh;
    @(negedge clk);
    in_d = vecs[1].din; sh_d = vecs[1].sh;
    @(negedge clk);
    vi = 1'b0;
    #1;
    chk("reset_inflight_valid", 64'(vo), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_flush_valid", 64'(vo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    any = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      any = any | vo;
    end
    chk("reset_no_stale", 64'(any), 64'd0);
    chk("reset_readyIn_after", 64'(ri), 64'd1);

    sweep_go = 1'b1;
    for (int t = 0; t < 20000 && sweep_done < 5; t++) @(posedge clk);
    chk("sweep_complete", 64'(sweep_done), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Random sweeps against the golden model, one DUT per width
  for (genvar g = 0; g < 5; g++) begin : g_sweep
    localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 13 : (g == 3) ? 16 : 33;
    localparam int SWS = $clog2(W);

    logic [W-1:0]   din, dout;
    logic [SWS-1:0] dsh;
    logic           svi, sri, svo, sro;
    logic [W-1:0]   sq[$];

    left_shift_pipelined #(.WIDTH(W)) u_dut (
      .clk(clk), .reset(reset), .in(din), .shift(dsh), .validIn(svi),
      .readyIn(sri), .out(dout), .validOut(svo), .readyOut(sro)
    );

    initial begin
      logic [W-1:0] e;
      int n;
      din = '0; dsh = '0; svi = 1'b0; sro = 1'b1;
      wait (sweep_go);
      n = 0;
      for (int c = 0; c < 320; c++) begin
        @(negedge clk);
        din = W'({$urandom(), $urandom()});
        dsh = SWS'($urandom_range(0, (1 << SWS) - 1));
        svi = (c < 300) && ($urandom_range(0, 3) != 0);
        sro = (c >= 300) || ($urandom_range(0, 3) != 0);
        #1;
        if (svo && sro) begin
          if (sq.size() > 0) chk($sformatf("sweep_w%0d_out%0d", W, n), 64'(dout), 64'(sq.pop_front()));
          else chk($sformatf("sweep_w%0d_extra", W), 64'(svo), 64'd0);
          n++;
        end
        if (svi && sri) begin
          e = din << dsh;
          sq.push_back(e);
        end
      end
      chk($sformatf("sweep_w%0d_drained", W), 64'(sq.size()), 64'd0);
      sweep_done++;
    end
  end

endmodule
